// File: rtl/physics_step_ctrl.sv
// physics_step_ctrl: per-frame tilt/sine/velocity/position sequencer for the balance board
// Ports: clk, rst (sync active-low), frame_tick, BUTTON[4:0] (X+,X-,Y+,Y-,recenter),
//   sin_addr/sin_req/sin_data (shared sine ROM, SIN_LAT read latency),
//   position_x/y, velocity_x/y, sin_x/y (signed 11-bit), busy, frame_done, overrun (sticky).
// Optional macro BOUNCE_EN: wall hits reflect damped velocity instead of stopping the ball.
module physics_step_ctrl #(
  parameter int SIN_LAT      = 1,
  parameter int ANGLE_MAX    = 16,
  parameter int GSHIFT       = 2,
  parameter int VSHIFT       = 2,
  parameter int VMAX         = 255,
  parameter int POS_MIN      = 0,
  parameter int POS_MAX_X    = 639,
  parameter int POS_MAX_Y    = 479,
  parameter int POS_CENTER_X = 320,
  parameter int POS_CENTER_Y = 240
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic [4:0]  BUTTON,
  output logic [5:0]  sin_addr,
  output logic        sin_req,
  input  logic [10:0] sin_data,
  output logic [10:0] position_x,
  output logic [10:0] position_y,
  output logic [10:0] velocity_x,
  output logic [10:0] velocity_y,
  output logic [10:0] sin_x,
  output logic [10:0] sin_y,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun
);
  typedef enum logic [2:0] {IDLE, TILT, RD_X, RD_Y, UPD_V, UPD_P, DONE} state_t;
  localparam logic        [2:0]  LAT  = 3'(SIN_LAT);
  localparam logic signed [5:0]  AMAX = 6'(ANGLE_MAX);
  localparam logic signed [11:0] VMX  = 12'(VMAX);
  localparam logic signed [11:0] PMIN = 12'(POS_MIN);
  localparam logic signed [11:0] PMAX [2] = '{12'(POS_MAX_X), 12'(POS_MAX_Y)};
  localparam logic signed [10:0] CTR  [2] = '{11'(POS_CENTER_X), 11'(POS_CENTER_Y)};
  state_t             state_q;
  logic        [2:0]  cnt_q;
  logic signed [5:0]  ang_q [2];
  logic signed [5:0]  ang_d [2];
  logic signed [10:0] vel_q [2];
  logic signed [10:0] pos_q [2];
  logic signed [10:0] sin_q [2];
  logic signed [10:0] vel_n [2];
  logic signed [10:0] vel_p [2];
  logic signed [10:0] vel_w [2];
  logic signed [10:0] pos_n [2];
  logic signed [11:0] vs [2];
  logic signed [11:0] ps [2];
  logic        [5:0]  addr_q;
  logic               req_q, busy_q, done_q, ovr_q;
  // index 0 is the X axis, index 1 the Y axis; vel_q holds the UPD_V result when UPD_P reads it
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      ang_d[i] = BUTTON[4] ? '0 :
                 (BUTTON[2*i] && !BUTTON[2*i+1] && ang_q[i] < AMAX) ? ang_q[i] + 6'sd1 :
                 (BUTTON[2*i+1] && !BUTTON[2*i] && ang_q[i] > -AMAX) ? ang_q[i] - 6'sd1 : ang_q[i];
      vs[i] = 12'(vel_q[i]) + (12'(sin_q[i]) >>> GSHIFT);
      vel_n[i] = 11'(vs[i] > VMX ? VMX : vs[i] < -VMX ? -VMX : vs[i]);
      ps[i] = 12'(pos_q[i]) + (12'(vel_q[i]) >>> VSHIFT);
      pos_n[i] = 11'(ps[i] > PMAX[i] ? PMAX[i] : ps[i] < PMIN ? PMIN : ps[i]);
`ifdef BOUNCE_EN
      vel_w[i] = -(vel_q[i] >>> 1);
`else
      vel_w[i] = '0;
`endif
      vel_p[i] = (ps[i] > PMAX[i] || ps[i] < PMIN) ? vel_w[i] : vel_q[i];
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ang_q   <= '{default: '0};
      vel_q   <= '{default: '0};
      sin_q   <= '{default: '0};
      pos_q   <= CTR;
      addr_q  <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      req_q  <= 1'b0;
      done_q <= 1'b0;
      if (frame_tick && state_q != IDLE) ovr_q <= 1'b1;
      case (state_q)
        IDLE: if (frame_tick) begin
          state_q <= TILT;
          busy_q  <= 1'b1;
        end
        TILT: begin
          state_q <= RD_X;
          cnt_q   <= '0;
          req_q   <= 1'b1;
          addr_q  <= ang_d[0];
          ang_q   <= ang_d;
          if (BUTTON[4]) begin
            vel_q <= '{default: '0};
            pos_q <= CTR;
          end
        end
        // each read holds the address for SIN_LAT+1 cycles and captures on the last one
        RD_X, RD_Y: if (cnt_q == LAT) begin
          sin_q[state_q == RD_Y] <= sin_data;
          cnt_q   <= '0;
          state_q <= state_q == RD_X ? RD_Y : UPD_V;
          req_q   <= state_q == RD_X;
          addr_q  <= ang_q[1];
        end else cnt_q <= cnt_q + 3'd1;
        UPD_V: begin
          vel_q   <= vel_n;
          state_q <= UPD_P;
        end
        UPD_P: begin
          pos_q   <= pos_n;
          vel_q   <= vel_p;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign sin_addr   = addr_q;
  assign sin_req    = req_q;
  assign position_x = pos_q[0];
  assign position_y = pos_q[1];
  assign velocity_x = vel_q[0];
  assign velocity_y = vel_q[1];
  assign sin_x      = sin_q[0];
  assign sin_y      = sin_q[1];
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign overrun    = ovr_q;
endmodule

// File: tb/tb_physics_step_ctrl.sv
// tb_physics_step_ctrl: randomized frames against a frame-level reference model
module tb_physics_step_ctrl;
  localparam int L = 3, AM = 16, VM = 255, PMX = 330, PMY = 479, CX = 320, CY = 240;
  localparam int FD = 2 * L + 6;
  logic        clk = 0, rst = 0, frame_tick = 0;
  logic [4:0]  BUTTON = '0;
  logic [5:0]  sin_addr;
  logic        sin_req;
  logic [10:0] sin_data = '0;
  logic [10:0] position_x, position_y, velocity_x, velocity_y, sin_x, sin_y;
  logic        busy, frame_done, overrun;
  logic [10:0] pipe [L];
  int checks = 0, errors = 0;
  int ang [2], vel [2], pos [2], sn [2];
  int pmax [2] = '{PMX, PMY};
  int ovr;
  always #5 clk = ~clk;
  physics_step_ctrl #(.SIN_LAT(L), .POS_MAX_X(PMX)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .BUTTON(BUTTON),
    .sin_addr(sin_addr), .sin_req(sin_req), .sin_data(sin_data),
    .position_x(position_x), .position_y(position_y),
    .velocity_x(velocity_x), .velocity_y(velocity_y),
    .sin_x(sin_x), .sin_y(sin_y), .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );
  // sine ROM: data = 32*angle, valid exactly L cycles after the request, garbage otherwise
  always @(negedge clk) begin
    sin_data = pipe[L-1];
    for (int k = L - 1; k > 0; k--) pipe[k] = pipe[k-1];
    pipe[0] = sin_req ? 11'(32 * $signed(sin_addr)) : 11'($urandom);
  end
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  function automatic int wall(input int v);
`ifdef BOUNCE_EN
    return -(v >>> 1);
`else
    return 0;
`endif
  endfunction
  task automatic model_reset();
    ang = '{0, 0}; vel = '{0, 0}; sn = '{0, 0}; pos = '{CX, CY}; ovr = 0;
  endtask
  task automatic model_frame(input logic [4:0] b);
    int np;
    if (b[4]) begin
      ang = '{0, 0}; vel = '{0, 0}; pos = '{CX, CY};
    end else
      for (int i = 0; i < 2; i++) begin
        if (b[2*i] && !b[2*i+1]) ang[i] = ang[i] + 1 > AM ? AM : ang[i] + 1;
        else if (b[2*i+1] && !b[2*i]) ang[i] = ang[i] - 1 < -AM ? -AM : ang[i] - 1;
      end
    for (int i = 0; i < 2; i++) begin
      sn[i] = ang[i] * 32;
      vel[i] = vel[i] + (sn[i] >>> 2);
      if (vel[i] > VM) vel[i] = VM;
      if (vel[i] < -VM) vel[i] = -VM;
      np = pos[i] + (vel[i] >>> 2);
      if (np > pmax[i]) begin pos[i] = pmax[i]; vel[i] = wall(vel[i]); end
      else if (np < 0) begin pos[i] = 0; vel[i] = wall(vel[i]); end
      else pos[i] = np;
    end
  endtask
  task automatic check_state(input string tag);
    check({tag, "_px"}, int'($signed(position_x)), pos[0]);
    check({tag, "_py"}, int'($signed(position_y)), pos[1]);
    check({tag, "_vx"}, int'($signed(velocity_x)), vel[0]);
    check({tag, "_vy"}, int'($signed(velocity_y)), vel[1]);
    check({tag, "_sx"}, int'($signed(sin_x)), sn[0]);
    check({tag, "_sy"}, int'($signed(sin_y)), sn[1]);
  endtask
  // inj: cycle of the frame at which a second tick is pulsed (0 = none)
  task automatic run_frame(input logic [4:0] b, input int inj);
    model_frame(b);
    if (inj >= 1 && inj <= FD) ovr = 1;
    @(negedge clk);
    BUTTON = b;
    frame_tick = 1;
    @(negedge clk);
    for (int c = 1; c <= FD; c++) begin
      check("busy", int'(busy), 1);
      check("req", int'(sin_req), int'(c == 2 || c == L + 3));
      check("done", int'(frame_done), int'(c == FD));
      if (c >= 2 && c <= L + 2) check("addr_x", int'($signed(sin_addr)), ang[0]);
      if (c >= L + 3 && c <= 2 * L + 3) check("addr_y", int'($signed(sin_addr)), ang[1]);
      if (c == FD) check_state("frame");
      frame_tick = (c == inj);
      @(negedge clk);
    end
    frame_tick = 0;
    check("idle_busy", int'(busy), 0);
    check("idle_done", int'(frame_done), 0);
    check("overrun", int'(overrun), ovr);
  endtask
  initial begin
    logic [4:0] b;
    model_reset();
    repeat (3) @(negedge clk);
    check_state("reset");
    check("rst_busy", int'(busy), 0);
    check("rst_ovr", int'(overrun), 0);
    check("rst_req", int'(sin_req), 0);
    rst = 1;
    run_frame(5'b00001, 0);
    check("first_px", int'($signed(position_x)), 322);
    check("first_vx", int'($signed(velocity_x)), 8);
    repeat (20) run_frame(5'b00001, 0);
    check("sat_angle", ang[0], AM);
    check("wall_px", int'($signed(position_x)), PMX);
    run_frame(5'b00011, 0);
    run_frame(5'b00100, 0);
    run_frame(5'b10000, 0);
    run_frame(5'b01001, 3);
    run_frame(5'b01001, 0);
    run_frame(5'b00110, FD);
    // reset in the middle of RD_Y abandons the frame
    @(negedge clk);
    BUTTON = 5'b00001;
    frame_tick = 1;
    @(negedge clk);
    frame_tick = 0;
    repeat (L + 3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    rst = 1;
    model_reset();
    check_state("midrst");
    check("midrst_busy", int'(busy), 0);
    check("midrst_ovr", int'(overrun), 0);
    for (int c = 0; c < FD; c++) begin
      check("midrst_done", int'(frame_done), 0);
      @(negedge clk);
    end
    b = '0;
    for (int f = 0; f < 150; f++) begin
      if ($urandom_range(0, 3) == 0)
        b = 5'($urandom) & (($urandom_range(0, 12) == 0) ? 5'h1f : 5'h0f);
      run_frame(b, ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, FD)) : 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
